// File: rtl/mcpu_mio_bridge.sv
// CPU-to-MIO bus bridge: one-shot load/store requests become MIO bus cycles
// with bounded wait, alignment check, and a synchronised sticky interrupt flag.
module mcpu_mio_bridge #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ALIGN_BITS = 2,
  parameter int TIMEOUT    = 15,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              MIO_ready,
  input  logic [DATA_W-1:0] Data_in,
  output logic              CPU_MIO,
  output logic              mem_w,
  output logic [ADDR_W-1:0] Addr_out,
  output logic [DATA_W-1:0] Data_out,
  input  logic              INT,
  input  logic              int_clr,
  output logic              int_pending
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mio_q, mio_d;
  logic                memw_q, memw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                int_s1_q, int_s2_q, int_s3_q;
  logic                pend_q, pend_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    mio_d   = mio_q;
    memw_d  = memw_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_addr[ALIGN_BITS-1:0] != '0) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            mio_d   = 1'b1;
            memw_d  = cpu_we;
            addr_d  = cpu_addr;
            dout_d  = cpu_wdata;
            cnt_d   = '0;
          end
        end
      end
      ACCESS: begin
        if (MIO_ready || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Ready wins over timeout when both land in the last allowed cycle.
          if (MIO_ready && !memw_q) rdata_d = Data_in;
          err_d   = !MIO_ready;
          ack_d   = 1'b1;
          state_d = RESP;
          mio_d   = 1'b0;
          memw_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        // Arriving without ack means the misaligned path: spend one more cycle
        // so its ack lands at the same latency as a zero-wait access.
        if (!ack_q) begin
          ack_d = 1'b1;
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    pend_d = pend_q;
    if (int_clr) pend_d = 1'b0;
    if (int_s2_q && !int_s3_q) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      mio_q    <= 1'b0;
      memw_q   <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      int_s1_q <= 1'b0;
      int_s2_q <= 1'b0;
      int_s3_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      mio_q    <= mio_d;
      memw_q   <= memw_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      int_s1_q <= INT;
      int_s2_q <= int_s1_q;
      int_s3_q <= int_s2_q;
      pend_q   <= pend_d;
    end
  end

  assign cpu_busy    = busy_q;
  assign cpu_ack     = ack_q;
  assign cpu_err     = err_q;
  assign cpu_rdata   = rdata_q;
  assign CPU_MIO     = mio_q;
  assign mem_w       = memw_q;
  assign Addr_out    = addr_q;
  assign Data_out    = dout_q;
  assign int_pending = pend_q;

endmodule

// File: tb/tb_mcpu_mio_bridge.sv
// Scoreboard bench for mcpu_mio_bridge: issued requests push expected responses,
// a negedge monitor pops and compares on each cpu_ack.
module tb_mcpu_mio_bridge;
  localparam int TO = 15;

  logic        clk = 0, reset = 1;
  logic        cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        cpu_busy, cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic        MIO_ready = 0;
  logic [31:0] Data_in = 0;
  logic        CPU_MIO, mem_w;
  logic [31:0] Addr_out, Data_out;
  logic        INT = 0, int_clr = 0, int_pending;

  mcpu_mio_bridge #(.DATA_W(32), .ADDR_W(32), .ALIGN_BITS(2), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready), .Data_in(Data_in), .CPU_MIO(CPU_MIO),
    .mem_w(mem_w), .Addr_out(Addr_out), .Data_out(Data_out), .INT(INT),
    .int_clr(int_clr), .int_pending(int_pending));

  always #5 clk = ~clk;

  typedef struct {bit err; logic [31:0] rdata; int lat; int mio; int req_cyc;} exp_t;
  exp_t sbq[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  logic [31:0] model_rdata = 0;
  int slave_wait = 0;
  logic [31:0] slave_data = 0;
  logic [31:0] cur_addr = 0, cur_wdata = 0;
  logic        cur_we = 0;
  int mio_cnt = 0, bus_bad = 0, acc_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave: asserts ready in access cycle slave_wait+1, junk data otherwise.
  always @(negedge clk) begin
    if (CPU_MIO) acc_cnt = acc_cnt + 1; else acc_cnt = 0;
    MIO_ready = CPU_MIO && (acc_cnt == slave_wait + 1);
    Data_in   = MIO_ready ? slave_data : $urandom;
  end

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (reset) begin
      mio_cnt = 0;
      bus_bad = 0;
    end else begin
      if (CPU_MIO) begin
        mio_cnt++;
        if (Addr_out !== cur_addr || mem_w !== cur_we || Data_out !== cur_wdata) bus_bad++;
      end
      if (cpu_ack) begin
        chk("ack_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("err", cpu_err, e.err);
          chk("rdata", cpu_rdata, e.rdata);
          chk("latency", cyc - e.req_cyc, e.lat);
          chk("mio_cycles", mio_cnt, e.mio);
          chk("bus_stable", bus_bad, 0);
        end
        mio_cnt = 0;
        bus_bad = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string nm);
    @(negedge clk);
    chk(nm, {cpu_busy, cpu_ack, cpu_err, cpu_rdata, CPU_MIO, mem_w, Addr_out, Data_out, int_pending}, '0);
  endtask

  // Issue one request (caller is idle, just after a posedge) and wait for idle.
  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input int w, input logic [31:0] rd);
    exp_t e;
    bit mis, tmo;
    int k;
    mis = (addr[1:0] != 2'b00);
    tmo = !mis && (w >= TO);
    if (!mis && !tmo && !we) model_rdata = rd;
    e.err = mis || tmo;
    e.rdata = model_rdata;
    e.lat = mis ? 2 : (tmo ? TO + 1 : w + 2);
    e.mio = mis ? 0 : (tmo ? TO : w + 1);
    e.req_cyc = cyc;
    sbq.push_back(e);
    if (!mis) begin
      cur_addr = addr; cur_we = we; cur_wdata = wd;
    end
    slave_wait = w; slave_data = rd;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1;
    tick();
    cpu_req = 0;
    if ($urandom_range(0, 2) == 0) begin
      cpu_req = 1; cpu_addr = $urandom; cpu_we = $urandom_range(0, 1); cpu_wdata = $urandom;
      tick();
      cpu_req = 0;
    end
    k = 0;
    while (cpu_busy && k < 60) begin
      tick();
      k++;
    end
    if (k >= 60) chk("idle_timeout", cpu_busy, 0);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 0;
    check_zero("reset_state");
    tick();
    // Directed cases, then boundary waits, then random traffic.
    issue(0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    issue(1, 32'h204, 32'h12345678, 3, 32'hCAFE0000);
    issue(0, 32'h102, 32'h0, 0, 32'h11111111);
    issue(0, 32'h400, 32'h0, 100, 32'h22222222);
    issue(0, 32'h404, 32'h0, 0, 32'h33333333);
    issue(0, 32'h408, 32'h0, TO - 1, 32'h44444444);
    issue(1, 32'h40C, 32'h55555555, TO, 32'h66666666);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int w;
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 6);
      issue($urandom_range(0, 1), a, $urandom, w, $urandom);
    end

    // Reset during the second access cycle aborts with no ack.
    slave_wait = 100;
    cur_addr = 32'h300; cur_we = 0; cur_wdata = 32'h0;
    cpu_addr = 32'h300; cpu_we = 0; cpu_wdata = 0; cpu_req = 1;
    tick();
    cpu_req = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    model_rdata = 0;
    check_zero("reset_abort");
    repeat (4) tick();
    issue(0, 32'h500, 32'h0, 1, 32'hA5A5A5A5);

    // Interrupt synchroniser and sticky flag.
    INT = 1; tick(); INT = 0;
    tick();
    @(negedge clk); chk("int_early", int_pending, 0);
    tick();
    @(negedge clk); chk("int_set", int_pending, 1);
    tick();
    INT = 1; tick(); tick();
    int_clr = 1; tick(); int_clr = 0;
    @(negedge clk); chk("int_set_wins", int_pending, 1);
    tick();
    int_clr = 1; tick(); int_clr = 0;
    @(negedge clk); chk("int_clear", int_pending, 0);
    repeat (4) tick();
    @(negedge clk); chk("int_level_no_reset", int_pending, 0);
    INT = 0;

    repeat (3) tick();
    chk("sb_drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end
endmodule
